// File: rtl/smart_thermostat_if.sv
// Signal bundle between the temperature front end and the thermostat core.
// The master drives the temperatures and reads back the relay enables.
interface smart_thermostat_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] current_temp;
  logic [WIDTH-1:0] set_temp;
  logic [WIDTH-1:0] margin;
  logic             heating;
  logic             cooling;

  modport master (
    output current_temp, set_temp, margin,
    input  heating, cooling
  );

  modport slave (
    input  current_temp, set_temp, margin,
    output heating, cooling
  );
endinterface

// File: rtl/smart_thermostat.sv
// Hysteresis HVAC controller: compares the room temperature against a setpoint +/- margin band
// and drives mutually exclusive heater/cooler enables, with a guaranteed idle gap between modes.
module smart_thermostat #(
  parameter int WIDTH    = 8,
  parameter int MIN_IDLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  smart_thermostat_if.slave thermo
);

  localparam int CNT_W = $clog2(MIN_IDLE + 1);

  typedef enum logic [1:0] {
    IDLE,
    HEAT,
    COOL
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_next;
  logic             fresh, fresh_next;

  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] low, high;
  logic             heat_req, cool_req, idle_done;

  // Thresholds clamp instead of wrapping so extreme setpoints still behave sensibly.
  assign sum_wide = {1'b0, thermo.set_temp} + {1'b0, thermo.margin};
  assign high     = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
  assign low      = (thermo.margin > thermo.set_temp) ? '0 : (thermo.set_temp - thermo.margin);

  assign heat_req  = (thermo.current_temp <= low)  && (thermo.current_temp < thermo.set_temp);
  assign cool_req  = (thermo.current_temp >= high) && (thermo.current_temp > thermo.set_temp);
  // fresh marks "no mode has run since reset", so the first activation needs no idle wait.
  assign idle_done = fresh || (idle_cnt >= CNT_W'(MIN_IDLE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      fresh    <= 1'b1;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      fresh    <= fresh_next;
    end
  end

  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    fresh_next    = fresh;
    case (state)
      IDLE: begin
        if (heat_req && idle_done) begin
          state_next = HEAT;
          fresh_next = 1'b0;
        end else if (cool_req && idle_done) begin
          state_next = COOL;
          fresh_next = 1'b0;
        end else if (idle_cnt < CNT_W'(MIN_IDLE)) begin
          idle_cnt_next = idle_cnt + CNT_W'(1);
        end
      end
      HEAT: begin
        if (thermo.current_temp >= thermo.set_temp) begin
          state_next    = IDLE;
          idle_cnt_next = '0;
        end
      end
      COOL: begin
        if (thermo.current_temp <= thermo.set_temp) begin
          state_next    = IDLE;
          idle_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        idle_cnt_next = '0;
      end
    endcase
  end

  assign thermo.heating = (state == HEAT);
  assign thermo.cooling = (state == COOL);

endmodule

// File: tb/tb_smart_thermostat.sv
// Scoreboard bench for smart_thermostat: a behavioural model pushes the expected enables per
// driven cycle, and each scenario task pops and compares them after the clock edge.
module tb_smart_thermostat;

  localparam int WIDTH    = 8;
  localparam int MIN_IDLE = 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [1:0] sb[$];
  int         m_state;
  int         m_cnt;
  bit         m_fresh;

  smart_thermostat_if #(.WIDTH(WIDTH)) ifc ();

  smart_thermostat #(
    .WIDTH    (WIDTH),
    .MIN_IDLE (MIN_IDLE)
  ) dut (
    .clk    (clk),
    .reset  (rst),
    .thermo (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the reference model, and leave sampling time #1 past the edge.
  task automatic step(input bit r, input int t, input int s, input int m);
    int lo, hi;
    bit ok;
    rst              = r;
    ifc.current_temp = WIDTH'(t);
    ifc.set_temp     = WIDTH'(s);
    ifc.margin       = WIDTH'(m);
    lo = (s - m < 0) ? 0 : s - m;
    hi = (s + m > 255) ? 255 : s + m;
    if (!r) begin
      m_state = 0;
      m_cnt   = 0;
      m_fresh = 1'b1;
    end else begin
      case (m_state)
        0: begin
          ok = m_fresh || (m_cnt >= MIN_IDLE);
          if (ok && t <= lo && t < s) begin
            m_state = 1;
            m_fresh = 1'b0;
          end else if (ok && t >= hi && t > s) begin
            m_state = 2;
            m_fresh = 1'b0;
          end else if (m_cnt < MIN_IDLE) begin
            m_cnt++;
          end
        end
        1: if (t >= s) begin m_state = 0; m_cnt = 0; end
        default: if (t <= s) begin m_state = 0; m_cnt = 0; end
      endcase
    end
    sb.push_back({m_state == 1, m_state == 2});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] got;
    logic [1:0] exp;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 10 + 20 * i, 22, 2);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== 2'b00 || got !== exp) begin
        bad++;
        $display("[TB] FAIL reset_hold[%0d]: got=%b want=00", i, got);
      end
    end
    step(1'b1, 20, 22, 2);
    exp = sb.pop_front();
    got = {ifc.heating, ifc.cooling};
    total++;
    if (got !== 2'b10 || got !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release_heat: got=%b want=10", got);
    end
  endtask

  task automatic test_heat_exit();
    int temps[3] = '{18, 21, 22};
    logic [1:0] want[3] = '{2'b10, 2'b10, 2'b00};
    logic [1:0] got;
    logic [1:0] exp;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, temps[i], 22, 2);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== want[i] || got !== exp) begin
        bad++;
        $display("[TB] FAIL heat_exit temp=%0d: got=%b want=%b", temps[i], got, want[i]);
      end
    end
  endtask

  task automatic test_cool_band();
    int temps[4] = '{23, 24, 23, 22};
    logic [1:0] want[4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    logic [1:0] got;
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, temps[i], 22, 2);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== want[i] || got !== exp) begin
        bad++;
        $display("[TB] FAIL cool_band temp=%0d: got=%b want=%b", temps[i], got, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got;
    logic [1:0] exp;
    int idle_cycles;
    bit cooled;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 18, 22, 2);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_heat_up[%0d]: got=%b want=%b", i, got, exp);
      end
    end
    idle_cycles = 0;
    cooled      = 1'b0;
    for (int i = 0; i < 10 && !cooled; i++) begin
      step(1'b1, 30, 22, 2);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== exp || got === 2'b11 || (i == 0 && got !== 2'b00)) begin
        bad++;
        $display("[TB] FAIL b2b_switch[%0d]: got=%b want=%b", i, got, exp);
      end
      if (got === 2'b00) idle_cycles++;
      if (got === 2'b01) cooled = 1'b1;
    end
    total++;
    if (!cooled || idle_cycles < MIN_IDLE) begin
      bad++;
      $display("[TB] FAIL b2b_idle_gap: cooled=%0d idle_cycles=%0d want cooled=1 idle>=%0d",
               cooled, idle_cycles, MIN_IDLE);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] got;
    logic [1:0] exp;
    step(1'b0, 0, 0, 0);
    void'(sb.pop_front());
    step(1'b1, 255, 250, 10);
    exp = sb.pop_front();
    got = {ifc.heating, ifc.cooling};
    total++;
    if (got !== 2'b01 || got !== exp) begin
      bad++;
      $display("[TB] FAIL sat_high: got=%b want=01", got);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 5, 10);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL sat_low_walk[%0d]: got=%b want=%b", i, got, exp);
      end
    end
    total++;
    if (got !== 2'b10) begin
      bad++;
      $display("[TB] FAIL sat_low: got=%b want=10", got);
    end
  endtask

  task automatic test_margin_zero();
    int temps[7] = '{22, 22, 21, 21, 23, 23, 23};
    logic [1:0] want[7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [1:0] got;
    logic [1:0] exp;
    step(1'b1, 22, 22, 0);
    void'(sb.pop_front());
    step(1'b1, 22, 22, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      step(1'b1, temps[i], 22, 0);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== want[i] || got !== exp) begin
        bad++;
        $display("[TB] FAIL margin_zero[%0d] temp=%0d: got=%b want=%b", i, temps[i], got, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] got;
    logic [1:0] exp;
    int t, s, m;
    bit r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 255);
        s = $urandom_range(0, 255);
        m = $urandom_range(0, 255);
      end else begin
        t = $urandom_range(14, 30);
        s = $urandom_range(20, 24);
        m = $urandom_range(0, 3);
      end
      step(r, t, s, m);
      exp = sb.pop_front();
      got = {ifc.heating, ifc.cooling};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL random[%0d] r=%0d t=%0d s=%0d m=%0d: got=%b want=%b",
                 i, r, t, s, m, got, exp);
      end
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b0;
    ifc.current_temp = '0;
    ifc.set_temp     = '0;
    ifc.margin       = '0;
    m_state          = 0;
    m_cnt            = 0;
    m_fresh          = 1'b1;
    test_reset();
    test_heat_exit();
    test_cool_band();
    test_back_to_back();
    test_saturation();
    test_margin_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
